// File: rtl/pe_pkg.sv
// Shared constants and bus types for the priority-evaluation window logic.
package pe_pkg;

  localparam int unsigned SCREEN_W = 240;
  localparam int unsigned SCREEN_H = 160;
  localparam int unsigned LINE_MAX = 227;
  localparam int unsigned COORD_W  = 8;

  // Window bound register layout: lo in [15:8] (inclusive), hi in [7:0] (exclusive).
  typedef struct packed {
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
  } win_bounds_t;

endpackage

// File: rtl/pe_window_range.sv
// Single-axis window membership test with wrap-around and empty-window handling.
module pe_window_range
  import pe_pkg::*;
(
  input  logic [COORD_W-1:0] c,
  input  win_bounds_t        bounds,
  output logic               hit_c
);

  always_comb begin
    hit_c = 1'b0;
    if (bounds.lo < bounds.hi) begin
      hit_c = (c >= bounds.lo) && (c < bounds.hi);
    end else if (bounds.lo > bounds.hi) begin
      hit_c = (c >= bounds.lo) || (c < bounds.hi);
    end
  end

endmodule

// File: rtl/pe_window_detector.sv
// Per-pixel WIN0/WIN1/obj hit generator: per-line bound shadows, x counter,
// vertical flags and a one-cycle output register.
module pe_window_detector #(
  parameter int unsigned SCREEN_W = pe_pkg::SCREEN_W,
  parameter int unsigned LINE_MAX = pe_pkg::LINE_MAX
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  vcount,
  input  logic        pixel_valid,
  input  logic        obj_win_in,
  input  logic [15:0] WIN0H,
  input  logic [15:0] WIN1H,
  input  logic [15:0] WIN0V,
  input  logic [15:0] WIN1V,
  output logic        out_valid,
  output logic [7:0]  out_x,
  output logic        WIN0,
  output logic        WIN1,
  output logic        obj,
  output logic        overrun
);

  import pe_pkg::*;

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] LINE_LAST = COORD_W'(LINE_MAX);

  // Vertical bounds only matter at line_start, so the latched v flags are
  // their per-line shadow; horizontal bounds are shadowed explicitly.
  win_bounds_t        h0_shadow;
  win_bounds_t        h1_shadow;
  logic               v0;
  logic               v1;
  logic [COORD_W-1:0] x;
  logic               line_done;

  logic h0_hit_c;
  logic h1_hit_c;
  logic v0_hit_c;
  logic v1_hit_c;
  logic line_ok_c;
  logic accept_c;
  logic emit_c;

  pe_window_range u_h0 (.c(x),      .bounds(h0_shadow),           .hit_c(h0_hit_c));
  pe_window_range u_h1 (.c(x),      .bounds(h1_shadow),           .hit_c(h1_hit_c));
  pe_window_range u_v0 (.c(vcount), .bounds(win_bounds_t'(WIN0V)), .hit_c(v0_hit_c));
  pe_window_range u_v1 (.c(vcount), .bounds(win_bounds_t'(WIN1V)), .hit_c(v1_hit_c));

  // Out-of-range line numbers never open a vertical window.
  assign line_ok_c = (vcount <= LINE_LAST);
  assign accept_c  = pixel_valid & ~line_start;
  assign emit_c    = accept_c & ~line_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h0_shadow <= '0;
      h1_shadow <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      x         <= '0;
      line_done <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      WIN0      <= 1'b0;
      WIN1      <= 1'b0;
      obj       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= emit_c;
      if (line_start) begin
        h0_shadow <= win_bounds_t'(WIN0H);
        h1_shadow <= win_bounds_t'(WIN1H);
        v0        <= v0_hit_c & line_ok_c;
        v1        <= v1_hit_c & line_ok_c;
        x         <= '0;
        line_done <= 1'b0;
        overrun   <= 1'b0;
      end else if (pixel_valid) begin
        if (line_done) begin
          overrun <= 1'b1;
        end else if (x == X_LAST) begin
          line_done <= 1'b1;
        end else begin
          x <= x + COORD_W'(1);
        end
      end
      // Result fields hold between accepted strobes.
      if (emit_c) begin
        out_x <= x;
        WIN0  <= h0_hit_c & v0;
        WIN1  <= h1_hit_c & v1;
        obj   <= obj_win_in;
      end
    end
  end

endmodule

// File: tb/tb_pe_window_detector.sv
// Directed plus randomized bench for pe_window_detector against a per-line pixel model.
module tb_pe_window_detector;

  localparam int SCREEN_W = 240;

  logic        clock;
  logic        reset_n;
  logic        line_start;
  logic [7:0]  vcount;
  logic        pixel_valid;
  logic        obj_win_in;
  logic [15:0] WIN0H, WIN1H, WIN0V, WIN1V;
  logic        out_valid;
  logic [7:0]  out_x;
  logic        WIN0, WIN1, obj, overrun;

  pe_window_detector dut (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .vcount(vcount),
    .pixel_valid(pixel_valid), .obj_win_in(obj_win_in),
    .WIN0H(WIN0H), .WIN1H(WIN1H), .WIN0V(WIN0V), .WIN1V(WIN1V),
    .out_valid(out_valid), .out_x(out_x), .WIN0(WIN0), .WIN1(WIN1),
    .obj(obj), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: bounds latched per line, vertical verdicts, pixels seen this line.
  logic [15:0] m_h0, m_h1;
  logic        m_v0, m_v1;
  int          m_count;
  logic        e_valid, e_w0, e_w1, e_obj, e_ovr;
  logic [7:0]  e_x;

  int hits0, hits1, valids;

  // Window of length (hi-lo) mod 256 starting at lo, on a 256-value circle.
  function automatic logic in_range(input int c, input logic [15:0] b);
    int lo, hi;
    lo = int'(b[15:8]);
    hi = int'(b[7:0]);
    return ((c - lo + 256) % 256) < ((hi - lo + 256) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_count = 0;
    e_valid = 1'b0; e_x = '0; e_w0 = 1'b0; e_w1 = 1'b0; e_obj = 1'b0; e_ovr = 1'b0;
  endtask

  task automatic step(input logic r, input logic ls, input logic [7:0] vc,
                      input logic pv, input logic ow);
    reset_n = r; line_start = ls; vcount = vc; pixel_valid = pv; obj_win_in = ow;
    if (!r) begin
      model_reset();
    end else begin
      e_valid = 1'b0;
      if (ls) begin
        m_h0 = WIN0H; m_h1 = WIN1H;
        m_v0 = in_range(int'(vc), WIN0V);
        m_v1 = in_range(int'(vc), WIN1V);
        m_count = 0;
        e_ovr = 1'b0;
      end else if (pv) begin
        if (m_count < SCREEN_W) begin
          e_valid = 1'b1;
          e_x     = 8'(m_count);
          e_w0    = in_range(m_count, m_h0) & m_v0;
          e_w1    = in_range(m_count, m_h1) & m_v1;
          e_obj   = ow;
          m_count++;
        end else begin
          e_ovr = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_x",     32'(out_x),     32'(e_x));
    chk("WIN0",      32'(WIN0),      32'(e_w0));
    chk("WIN1",      32'(WIN1),      32'(e_w1));
    chk("obj",       32'(obj),       32'(e_obj));
    chk("overrun",   32'(overrun),   32'(e_ovr));
    if (out_valid) begin
      valids++;
      if (WIN0) hits0++;
      if (WIN1) hits1++;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    hits0 = 0; hits1 = 0; valids = 0;
  endtask

  // One line: line_start then n strobes, optionally with random idle gaps.
  task automatic run_line(input logic [7:0] vc, input int n, input bit gaps);
    step(1'b1, 1'b1, vc, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle();
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'($urandom));
    end
    idle();
  endtask

  initial begin
    model_reset();
    WIN0H = '0; WIN1H = '0; WIN0V = '0; WIN1V = '0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h12, 1'b1, 1'b1);
    idle();

    // Basic rectangle on window 0.
    WIN0H = 16'h1050; WIN0V = 16'h2030;
    clear_counts();
    run_line(8'h25, SCREEN_W, 1'b0);
    chk("line25_win0_hits", 32'(hits0), 32'd64);
    chk("line25_valids", 32'(valids), 32'd240);
    clear_counts();
    run_line(8'h30, SCREEN_W, 1'b1);
    chk("line30_win0_hits", 32'(hits0), 32'd0);

    // Wrap-around window 1.
    WIN1H = 16'hE020; WIN1V = 16'h9010;
    clear_counts();
    run_line(8'h05, SCREEN_W, 1'b0);
    chk("line05_win1_hits", 32'(hits1), 32'd48);
    clear_counts();
    run_line(8'h50, SCREEN_W, 1'b1);
    chk("line50_win1_hits", 32'(hits1), 32'd0);
    clear_counts();
    run_line(8'h90, SCREEN_W, 1'b0);
    chk("line90_win1_hits", 32'(hits1), 32'd48);

    // Empty window 0 across a few lines.
    WIN0H = 16'h4040; WIN0V = 16'h00E0;
    clear_counts();
    for (int l = 0; l < 3; l++) run_line(8'($urandom_range(0, 227)), SCREEN_W, 1'b1);
    chk("empty_win0_hits", 32'(hits0), 32'd0);

    // Mid-line bounds write takes effect next line only.
    WIN0H = 16'h0010; WIN0V = 16'h0050;
    clear_counts();
    step(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    WIN0H = 16'h80C0;
    for (int i = 100; i < SCREEN_W; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("midline_old_hits", 32'(hits0), 32'd16);
    clear_counts();
    run_line(8'h21, SCREEN_W, 1'b0);
    chk("midline_new_hits", 32'(hits0), 32'd64);

    // Overrun with 241 strobes, then strobe coincident with line_start.
    clear_counts();
    run_line(8'h10, SCREEN_W + 1, 1'b0);
    chk("overrun_valids", 32'(valids), 32'd240);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    idle();
    clear_counts();
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
    chk("coincident_no_valid", 32'(out_valid), 32'd0);
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Reset mid-line with obj asserted, then strobe without line_start.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("rst_obj", 32'(obj), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("post_rst_x", 32'(out_x), 32'd0);
    chk("post_rst_win", 32'({WIN0, WIN1}), 32'd0);
    idle();

    // Randomized bounds, lines and strobe patterns.
    for (int l = 0; l < 12; l++) begin
      WIN0H = 16'($urandom); WIN1H = 16'($urandom);
      WIN0V = 16'($urandom); WIN1V = 16'($urandom);
      step(1'b1, 1'b1, 8'($urandom_range(0, 227)), 1'b0, 1'b0);
      for (int i = 0; i < 250; i++) begin
        if (i == 120) WIN0H = 16'($urandom);
        step(1'b1, 1'($urandom_range(0, 199) == 0), 8'($urandom_range(0, 227)),
             1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_window_detector.md
# pe_window_detector

Per-pixel window hit generator for the priority-evaluation stage. It tracks the scanline position, latches per-line shadow copies of the WIN0/WIN1 rectangle registers, and evaluates horizontal and vertical range membership with GBA wrap-around semantics. It emits registered `WIN0`, `WIN1` and `obj` hit flags, one per pixel, that feed the window masker's window-select inputs. It sits between the scan timing / object renderer and the window masker.

## Interface

Parameters:
- `SCREEN_W`, 240, visible pixels per line; the x counter saturates at `SCREEN_W-1`.
- `LINE_MAX`, 227, highest legal `vcount` value.

Ports:
- `clock`  input  1  system clock; all state updates on its rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `line_start`  input  1  one-cycle pulse at the start of each scanline.
- `vcount`  input  8  current line number; sampled only when `line_start` is high.
- `pixel_valid`  input  1  one-cycle strobe per visible pixel, in x order.
- `obj_win_in`  input  1  object-window coverage for the pixel strobed this cycle.
- `WIN0H`, `WIN1H`  input  16  horizontal bounds: [15:8] is X1 (left, inclusive), [7:0] is X2 (right, exclusive).
- `WIN0V`, `WIN1V`  input  16  vertical bounds: [15:8] is Y1 (top, inclusive), [7:0] is Y2 (bottom, exclusive).
- `out_valid`  output  1  a pixel result is present this cycle.
- `out_x`  output  8  x coordinate of the result.
- `WIN0`, `WIN1`  output  1  pixel lies inside window 0 / window 1.
- `obj`  output  1  registered copy of `obj_win_in`.
- `overrun`  output  1  sticky flag: set when a `pixel_valid` strobe arrives after x has reached `SCREEN_W-1`. Cleared by the next `line_start`.

## Operation

- Shadow registers:
  - On `line_start`, copy `WIN0H`, `WIN1H`, `WIN0V` and `WIN1V` into shadows.
  - Writes to the bounds registers mid-line take effect only at the next `line_start`.
- Vertical flags `v0`, `v1`:
  - Evaluated on `line_start` from `vcount` and the incoming `WINxV` values (the same values being shadowed).
  - Held for the whole line.
- Range rule, identical on both axes, for coordinate c with bounds (A, B):
  - A < B: hit = A ≤ c < B.
  - A > B (wrap): hit = c ≥ A or c < B.
  - A == B: never hit (empty window).
- Per pixel:
  - `WIN0` = h0(x) & v0.
  - `WIN1` = h1(x) & v1.
  - No priority between the two windows here; both may be 1 at once, and the masker resolves priority.
  - Display enables (DISPCNT) are not applied in this block.
- x counter:
  - Cleared to 0 on `line_start`.
  - Each accepted `pixel_valid` produces a result for the current x, then x increments.
  - Once x = `SCREEN_W-1` has been emitted, further strobes on that line produce no `out_valid` and set `overrun`.
- `line_start` and `pixel_valid` in the same cycle: the strobe is dropped (no result, no count). `line_start` processing proceeds normally.
- Strobes before the first `line_start` after reset are evaluated with all-zero shadows, so `WIN0`/`WIN1` are 0.

## Timing

- Latency is 1 cycle: a strobe at cycle n gives `out_valid`=1 at n+1 carrying that pixel's x, `WIN0`, `WIN1` and `obj`.
- Throughput: one pixel per cycle; back-to-back strobes are legal.
- `out_valid` is a single-cycle pulse per accepted strobe. `out_x`, `WIN0`, `WIN1` and `obj` hold their last values when `out_valid` is 0.
- A strobe in the cycle immediately after `line_start` uses the new shadows and vertical flags.
- Reset (`reset_n`=0 at an edge) sets all outputs to 0: `out_valid`, `out_x`, `WIN0`, `WIN1`, `obj`, `overrun`. It also clears the shadows, `v0`/`v1` and x.
- Reset asserted mid-line aborts the line. No result is produced for a strobe coinciding with reset.

## Structure

- Shared package `pe_pkg` holds:
  - constants `SCREEN_W`=240, `SCREEN_H`=160, `LINE_MAX`=227;
  - a packed struct `win_bounds_t` {lo[7:0], hi[7:0]}.
- Sub-module `pe_window_range`: combinational single-axis comparator (c, A, B → hit) implementing the wrap/empty rule.
  - Instantiated four times: two horizontal, two vertical.
- Top level contains the shadow registers, vertical-flag registers, x counter, overrun flag and output pipeline register.

## Test plan

- WIN0H=0x1050, WIN0V=0x2030, line_start with vcount=0x25, then 240 strobes → `WIN0`=1 exactly for `out_x` 0x10..0x4F; `WIN0` is 0 on all pixels of line 0x30.
- Wrap: WIN1H=0xE020, WIN1V=0x9010 → on line 0x05, `WIN1`=1 for x 0..0x1F and 0xE0..0xEF; no hit on line 0x50 or line 0x90 x=0x30.
- Empty: WIN0H=0x4040 → `WIN0` never 1 on any line.
- Mid-line write of WIN0H after pixel 100 → current line unchanged; the new bounds apply from the next `line_start`.
- 241 strobes on one line → 240 `out_valid` pulses and `overrun`=1 until the next `line_start`. A strobe coincident with `line_start` yields no output.
- `reset_n` low for one cycle mid-line with `obj_win_in`=1 → all outputs 0 the following cycle; first post-reset strobe with no `line_start` yields `WIN0`=`WIN1`=0 at x=0.
